// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
// Address/data widths, reset PC, fetch state and buffer entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ifu_pkg;

  typedef logic [`ADDR_WIDTH-1:0] memAdx;
  typedef logic [`DATA_WIDTH-1:0] memWrd;

  localparam memAdx RESET_PC_DEFAULT = memAdx'('o200);

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    memAdx pc;
    memWrd word;
  } ibuf_ent_t;

endpackage

// File: rtl/ifu_inst_buf.sv
// In-order {pc, word} buffer between memory return and decode.
// Flush empties it; the head is held while the buffer is empty.
module ifu_inst_buf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  ibuf_ent_t push_ent,
  input  logic      pop,
  output ibuf_ent_t head,
  output logic      valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  ibuf_ent_t mem [DEPTH];
  ibuf_ent_t hold_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign valid  = count != '0;
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      // remember the last shown head for empty cycles
      if (valid) hold_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_ent;
          wr_ptr <= nxt(wr_ptr);
        end
        if (do_pop) rd_ptr <= nxt(rd_ptr);
        count <= count + CW'(push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush)
      assert (!(push && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, read requests, halt/redirect control.
// Returned words are queued in ifu_inst_buf for decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter memAdx RESET_PC  = RESET_PC_DEFAULT,
  parameter int    BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ifu_rd_req,
  output logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [`DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                   redirect_valid,
  input  logic [`ADDR_WIDTH-1:0] redirect_pc,
  input  logic                   halt,
  output logic                   inst_valid,
  output logic [`DATA_WIDTH-1:0] inst_data,
  output logic [`ADDR_WIDTH-1:0] inst_pc,
  input  logic                   inst_ready,
  output logic                   fetch_halted
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e state;
  fetch_state_e state_nxt;
  memAdx pc;
  memAdx pend_pc;
  logic pend;
  logic push;
  logic pop;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  ibuf_ent_t push_ent;
  ibuf_ent_t head;

  assign pop  = inst_valid && inst_ready;
  assign push = pend && !redirect_valid;
  assign push_ent = '{pc: pend_pc, word: ifu_rd_data};

  // the head leaving this cycle frees a slot for the next word
  assign occ = OW'(count) + OW'(pend) - OW'(pop);

  assign ifu_rd_req = rst_n
    && state == FETCH
    && !halt
    && !redirect_valid
    && occ < OW'(BUF_DEPTH);

  assign ifu_rd_addr  = pc;
  assign inst_data    = head.word;
  assign inst_pc      = head.pc;
  assign fetch_halted = state == HALTED;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (halt && !pend) state_nxt = HALTED;
      HALTED:  if (!halt) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc;
      else if (ifu_rd_req) pc <= pc + 1'b1;
      pend <= ifu_rd_req;
      if (ifu_rd_req) pend_pc <= pc;
    end
  end

  ifu_inst_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push    (push),
    .push_ent(push_ent),
    .pop     (pop),
    .head    (head),
    .valid   (inst_valid),
    .count   (count)
  );

endmodule
